// File: rtl/clock_ctrl.sv
// 24-hour clock with RUN/SET_H/SET_M button control and a 6-digit multiplexed BCD scan.
// Optional macro CLOCK_BLINK_EN adds blinking of the field being edited.
module clock_ctrl #(
    parameter int unsigned TICK_DIV = 50000000,
    parameter int unsigned SCAN_DIV = 50000
) (
    input  logic       clock,
    input  logic       reset_n,
    input  logic       btn_mode,
    input  logic       btn_inc,
    output logic [4:0] countH,
    output logic [5:0] countM,
    output logic [5:0] countS,
    output logic [1:0] mode,
    output logic       tick,
    output logic [3:0] digit,
    output logic [5:0] digit_sel
);

    localparam int unsigned TW = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
    localparam int unsigned SW = (SCAN_DIV > 2) ? $clog2(SCAN_DIV) : 1;
    localparam int unsigned IW = 3;

    typedef enum logic [1:0] {
        RUN     = 2'b00,
        SET_H   = 2'b01,
        SET_M   = 2'b10,
        ILLEGAL = 2'b11
    } state_e;

    state_e          state_q,     state_d;
    logic [TW-1:0]   pre_q,       pre_d;
    logic [4:0]      count_h_q,   count_h_d;
    logic [5:0]      count_m_q,   count_m_d;
    logic [5:0]      count_s_q,   count_s_d;
    logic [SW-1:0]   scan_q,      scan_d;
    logic [IW-1:0]   idx_q,       idx_d;
    logic            mode_prev_q, mode_prev_d;
    logic            inc_prev_q,  inc_prev_d;
    logic            mode_edge;
    logic            inc_edge;
    logic [5:0]      sel_raw;

`ifdef CLOCK_BLINK_EN
    logic [TW-1:0]   blink_cnt_q, blink_cnt_d;
    logic            phase_q,     phase_d;
`endif

    // State register; button history loads live levels in reset so a held button gives no edge.
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            state_q     <= RUN;
            pre_q       <= '0;
            count_h_q   <= '0;
            count_m_q   <= '0;
            count_s_q   <= '0;
            scan_q      <= '0;
            idx_q       <= '0;
            mode_prev_q <= btn_mode;
            inc_prev_q  <= btn_inc;
        end else begin
            state_q     <= state_d;
            pre_q       <= pre_d;
            count_h_q   <= count_h_d;
            count_m_q   <= count_m_d;
            count_s_q   <= count_s_d;
            scan_q      <= scan_d;
            idx_q       <= idx_d;
            mode_prev_q <= mode_prev_d;
            inc_prev_q  <= inc_prev_d;
        end
    end

    // Next-state: mode FSM, timekeeping and manual setting.
    always_comb begin
        state_d     = state_q;
        pre_d       = pre_q;
        count_h_d   = count_h_q;
        count_m_d   = count_m_q;
        count_s_d   = count_s_q;
        mode_prev_d = btn_mode;
        inc_prev_d  = btn_inc;
        mode_edge   = btn_mode & ~mode_prev_q;
        inc_edge    = btn_inc & ~inc_prev_q;
        tick        = (state_q == RUN) && (pre_q == TW'(TICK_DIV - 1));

        case (state_q)
            RUN: begin
                pre_d = tick ? '0 : pre_q + TW'(1);
                if (tick) begin
                    if (count_s_q == 6'd59) begin
                        count_s_d = '0;
                        if (count_m_q == 6'd59) begin
                            count_m_d = '0;
                            count_h_d = (count_h_q == 5'd23) ? 5'd0 : count_h_q + 5'd1;
                        end else begin
                            count_m_d = count_m_q + 6'd1;
                        end
                    end else begin
                        count_s_d = count_s_q + 6'd1;
                    end
                end
                // Entering SET drops the seconds; minute/hour carry of a coincident tick is kept.
                if (mode_edge) begin
                    state_d   = SET_H;
                    count_s_d = '0;
                    pre_d     = '0;
                end
            end
            SET_H: begin
                if (mode_edge) begin
                    state_d = SET_M;
                end else if (inc_edge) begin
                    count_h_d = (count_h_q == 5'd23) ? 5'd0 : count_h_q + 5'd1;
                end
            end
            SET_M: begin
                if (mode_edge) begin
                    state_d = RUN;
                    pre_d   = '0;
                end else if (inc_edge) begin
                    count_m_d = (count_m_q == 6'd59) ? 6'd0 : count_m_q + 6'd1;
                end
            end
            default: begin
                state_d = RUN;
                pre_d   = '0;
            end
        endcase
    end

    // Display scan: slot timer and digit index, independent of mode.
    always_comb begin
        scan_d = scan_q + SW'(1);
        idx_d  = idx_q;
        if (scan_q == SW'(SCAN_DIV - 1)) begin
            scan_d = '0;
            idx_d  = (idx_q == IW'(5)) ? '0 : idx_q + IW'(1);
        end
    end

    // Same-cycle BCD digit for the scanned position.
    always_comb begin
        digit = 4'd0;
        case (idx_q)
            3'd0:    digit = 4'(count_s_q % 6'd10);
            3'd1:    digit = 4'(count_s_q / 6'd10);
            3'd2:    digit = 4'(count_m_q % 6'd10);
            3'd3:    digit = 4'(count_m_q / 6'd10);
            3'd4:    digit = 4'(count_h_q % 5'd10);
            3'd5:    digit = 4'(count_h_q / 5'd10);
            default: digit = 4'd0;
        endcase
    end

    assign sel_raw = 6'b000001 << idx_q;

`ifdef CLOCK_BLINK_EN
    // Free-running blink phase, toggling every TICK_DIV cycles.
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            blink_cnt_q <= '0;
            phase_q     <= 1'b0;
        end else begin
            blink_cnt_q <= blink_cnt_d;
            phase_q     <= phase_d;
        end
    end

    always_comb begin
        blink_cnt_d = blink_cnt_q + TW'(1);
        phase_d     = phase_q;
        if (blink_cnt_q == TW'(TICK_DIV - 1)) begin
            blink_cnt_d = '0;
            phase_d     = ~phase_q;
        end
    end

    always_comb begin
        digit_sel = sel_raw;
        if (phase_q && (state_q == SET_H)) begin
            digit_sel = sel_raw & 6'b001111;
        end else if (phase_q && (state_q == SET_M)) begin
            digit_sel = sel_raw & 6'b110011;
        end
    end
`else
    assign digit_sel = sel_raw;
`endif

    assign countH = count_h_q;
    assign countM = count_m_q;
    assign countS = count_s_q;
    assign mode   = state_q;

endmodule

// File: tb/tb_clock_ctrl.sv
// Randomized self-checking bench for clock_ctrl against a time-of-day reference model.
module tb_clock_ctrl;

    localparam int unsigned TICK_DIV = 4;
    localparam int unsigned SCAN_DIV = 2;

    logic       clock;
    logic       reset_n;
    logic       btn_mode;
    logic       btn_inc;
    logic [4:0] countH;
    logic [5:0] countM;
    logic [5:0] countS;
    logic [1:0] mode;
    logic       tick;
    logic [3:0] digit;
    logic [5:0] digit_sel;

    clock_ctrl #(.TICK_DIV(TICK_DIV), .SCAN_DIV(SCAN_DIV)) dut (
        .clock(clock), .reset_n(reset_n), .btn_mode(btn_mode), .btn_inc(btn_inc),
        .countH(countH), .countM(countM), .countS(countS), .mode(mode),
        .tick(tick), .digit(digit), .digit_sel(digit_sel)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    int n_cmp = 0;
    int n_bad = 0;

    // Reference model: mode, time of day, cycles into the current second, cycles since reset.
    int m_mode, m_h, m_m, m_s, m_pre, m_scan;
    int m_pm, m_pi;
    int tick_seen;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic model_edge(input int rst, input int bm, input int bi);
        int me, ie, t, idx;
        if (rst == 0) begin
            m_mode = 0; m_h = 0; m_m = 0; m_s = 0; m_pre = 0; m_scan = 0;
        end else begin
            me = (bm == 1 && m_pm == 0) ? 1 : 0;
            ie = (bi == 1 && m_pi == 0) ? 1 : 0;
            if (m_mode == 0) begin
                if (m_pre == TICK_DIV - 1) begin
                    t = (m_h * 3600 + m_m * 60 + m_s + 1) % 86400;
                    m_h = t / 3600; m_m = (t / 60) % 60; m_s = t % 60;
                end
                m_pre = (m_pre + 1) % TICK_DIV;
            end
            if (me == 1) begin
                if (m_mode == 0) begin m_mode = 1; m_s = 0; m_pre = 0; end
                else if (m_mode == 1) m_mode = 2;
                else begin m_mode = 0; m_pre = 0; end
            end else if (ie == 1) begin
                if (m_mode == 1) m_h = (m_h + 1) % 24;
                else if (m_mode == 2) m_m = (m_m + 1) % 60;
            end
            m_scan++;
        end
        m_pm = bm; m_pi = bi;
        idx = 0;
    endtask

    task automatic check_all();
        int idx, v, d;
        idx = (m_scan / SCAN_DIV) % 6;
        v = (idx < 2) ? m_s : (idx < 4) ? m_m : m_h;
        d = (idx % 2 == 0) ? v % 10 : v / 10;
        chk("countH", 32'(countH), 32'(m_h));
        chk("countM", 32'(countM), 32'(m_m));
        chk("countS", 32'(countS), 32'(m_s));
        chk("mode", 32'(mode), 32'(m_mode));
        chk("tick", 32'(tick), (m_mode == 0 && m_pre == TICK_DIV - 1) ? 32'd1 : 32'd0);
        chk("digit", 32'(digit), 32'(d));
        chk("digit_sel", 32'(digit_sel), 32'(1) << idx);
        if (tick === 1'b1) tick_seen++;
    endtask

    task automatic cycle(input int bm, input int bi, input int rst);
        reset_n  = (rst != 0);
        btn_mode = (bm != 0);
        btn_inc  = (bi != 0);
        @(posedge clock);
        model_edge(rst, bm, bi);
        @(negedge clock);
        check_all();
    endtask

    task automatic press_mode();
        cycle(1, 0, 1);
        cycle(0, 0, 1);
    endtask

    task automatic press_inc(input int n);
        for (int k = 0; k < n; k++) begin
            cycle(0, 1, 1);
            cycle(0, 0, 1);
        end
    endtask

    initial begin
        int bm, bi, rst, lim;
        m_pm = 0; m_pi = 0; tick_seen = 0;
        reset_n = 1'b0; btn_mode = 1'b0; btn_inc = 1'b0;

        // Reset values
        cycle(0, 0, 0);
        cycle(0, 0, 0);
        chk("rst_h", 32'(countH), 0);
        chk("rst_m", 32'(countM), 0);
        chk("rst_s", 32'(countS), 0);
        chk("rst_mode", 32'(mode), 0);
        chk("rst_tick", 32'(tick), 0);
        chk("rst_sel", 32'(digit_sel), 32'b000001);
        chk("rst_digit", 32'(digit), 0);

        // Twelve RUN cycles give three ticks
        tick_seen = 0;
        for (int k = 0; k < 12; k++) cycle(0, 0, 1);
        chk("ticks12", 32'(tick_seen), 3);
        chk("s_after12", 32'(countS), 3);

        // Setting sequence with wraps and no carry
        press_mode();
        chk("set_h_mode", 32'(mode), 1);
        chk("set_h_s", 32'(countS), 0);
        press_inc(25);
        chk("h_wrap", 32'(countH), 1);
        press_mode();
        chk("set_m_mode", 32'(mode), 2);
        press_inc(61);
        chk("m_wrap", 32'(countM), 1);
        chk("m_nocarry", 32'(countH), 1);

        // Simultaneous mode and inc edges in SET_H
        press_mode();
        press_mode();
        chk("sim_pre", 32'(mode), 1);
        cycle(1, 1, 1);
        cycle(0, 0, 1);
        chk("sim_mode", 32'(mode), 2);
        chk("sim_h", 32'(countH), 1);

        // Preload 23:59 and run up to midnight
        cycle(0, 0, 0);
        press_mode();
        press_inc(23);
        press_mode();
        press_inc(59);
        press_mode();
        lim = 0;
        while (!(m_s == 59) && lim < 400) begin cycle(0, 0, 1); lim++; end
        chk("runup_timeout", (lim < 400) ? 32'd1 : 32'd0, 1);
        chk("pre_h", 32'(countH), 23);
        chk("pre_m", 32'(countM), 59);
        chk("pre_s", 32'(countS), 59);
        lim = 0;
        while (!(m_h == 0 && m_m == 0 && m_s == 0) && lim < 10) begin cycle(0, 0, 1); lim++; end
        chk("wrap_timeout", (lim < 10) ? 32'd1 : 32'd0, 1);
        chk("wrap_h", 32'(countH), 0);
        chk("wrap_m", 32'(countM), 0);
        chk("wrap_s", 32'(countS), 0);

        // 12:34 then run through :56, scan compared each cycle
        cycle(0, 0, 0);
        press_mode();
        press_inc(12);
        press_mode();
        press_inc(34);
        press_mode();
        for (int k = 0; k < 240; k++) cycle(0, 0, 1);

        // Reset with btn_mode held mid-SET_M
        press_mode();
        press_mode();
        chk("r35_pre", 32'(mode), 2);
        cycle(1, 0, 0);
        chk("r35_mode", 32'(mode), 0);
        chk("r35_sel", 32'(digit_sel), 32'b000001);
        for (int k = 0; k < 3; k++) cycle(1, 0, 1);
        chk("r35_held", 32'(mode), 0);
        cycle(0, 0, 1);
        cycle(1, 0, 1);
        chk("r35_repress", 32'(mode), 1);

        // Random buttons and occasional resets
        bm = 0; bi = 0;
        for (int k = 0; k < 3000; k++) begin
            if ($urandom_range(0, 5) == 0) bm = 1 - bm;
            if ($urandom_range(0, 3) == 0) bi = 1 - bi;
            rst = ($urandom_range(0, 199) == 0) ? 0 : 1;
            cycle(bm, bi, rst);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
